i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx_if.sv | 32 +++
 rtl/i2s_tx.sv | 106 ++++++++++
 tb/tb_i2s_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// Stereo sample handshake plus serial I2S outputs of the transmitter.
interface i2s_tx_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              in_ready;
  logic              out_valid;
  logic              WS;
  logic              SD;

  modport master (
    output in_valid,
    output in_left,
    output in_right,
    input  in_ready,
    input  out_valid,
    input  WS,
    input  SD
  );

  modport slave (
    input  in_valid,
    input  in_left,
    input  in_right,
    output in_ready,
    output out_valid,
    output WS,
    output SD
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry holding register feeding left/right
// shifters, gapless frames, registered WS/SD/out_valid.
module i2s_tx #(
  parameter int DATA_W = 32
) (
  input logic     clk,
  input logic     rst,
  i2s_tx_if.slave bus
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_t;

  state_t            r_state, w_state;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic              r_full, w_full;
  logic [DATA_W-1:0] r_hold_l, r_hold_r;
  logic [DATA_W-1:0] r_sh_l, r_sh_r;
  logic [DATA_W-1:0] w_sh_l, w_sh_r;
  logic              r_valid, r_ws, r_sd;
  logic              w_valid, w_ws, w_sd;
  logic              w_accept, w_load;

  assign bus.in_ready  = ~r_full & ~rst;
  assign w_accept      = bus.in_valid & ~r_full & ~rst;
  assign bus.out_valid = r_valid;
  assign bus.WS        = r_ws;
  assign bus.SD        = r_sd;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sh_l  = r_sh_l;
    w_sh_r  = r_sh_r;
    w_load  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_full) w_load = 1'b1;
      end
      LEFT: begin
        w_sh_l = r_sh_l << 1;
        w_cnt  = r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          w_state = RIGHT;
          w_cnt   = '0;
        end
      end
      RIGHT: begin
        w_sh_r = r_sh_r << 1;
        w_cnt  = r_cnt + 1'b1;
        if (r_cnt == LAST) begin
          w_cnt = '0;
          if (r_full) w_load = 1'b1;
          else        w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
    if (w_load) begin
      w_state = LEFT;
      w_cnt   = '0;
      w_sh_l  = r_hold_l;
      w_sh_r  = r_hold_r;
    end
    w_full = w_load ? 1'b0 : (r_full | w_accept);
    // Outputs follow the next shifter MSB so WS and data switch together.
    w_valid = (w_state != IDLE);
    w_ws    = (w_state == RIGHT);
    w_sd    = 1'b0;
    if (w_state == LEFT)  w_sd = w_sh_l[DATA_W-1];
    if (w_state == RIGHT) w_sd = w_sh_r[DATA_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_sh_l   <= '0;
      r_sh_r   <= '0;
      r_valid  <= 1'b0;
      r_ws     <= 1'b0;
      r_sd     <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_full  <= w_full;
      r_sh_l  <= w_sh_l;
      r_sh_r  <= w_sh_r;
      r_valid <= w_valid;
      r_ws    <= w_ws;
      r_sd    <= w_sd;
      if (w_accept) begin
        r_hold_l <= bus.in_left;
        r_hold_r <= bus.in_right;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-timing model, backpressure, reset abort,
// behavioural receiver loopback and a 16-bit instance.
module tb_i2s_tx;
  typedef struct {
    int          acc;
    int          start;
    logic [31:0] l;
    logic [31:0] r;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_tx_if #(.DATA_W(32)) d ();
  i2s_tx_if #(.DATA_W(16)) e ();

  i2s_tx #(.DATA_W(32)) u32 (
    .clk(clk), .rst(rst), .bus(d.slave)
  );
  i2s_tx #(.DATA_W(16)) u16 (
    .clk(clk), .rst(rst), .bus(e.slave)
  );

  frame_t      q0[$];
  frame_t      q1[$];
  int          end0, end1;
  int          cyc, checks, errors;
  int          run0, last0, run1, last1;
  int          last_acc;
  bit          rx_on;
  logic [31:0] rxl, rxr;
  int          rxc;
  logic [63:0] sent[$];
  logic [63:0] rcvd[$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  // Frame k starts at max(accept+2, end of frame k-1), 2*dw cycles.
  task automatic expect_at(input int w, input int t,
                           output logic ov, output logic ws,
                           output logic sd, output logic rdy);
    frame_t q[$];
    int dw, o;
    q   = w ? q1 : q0;
    dw  = w ? 16 : 32;
    ov  = 1'b0;
    ws  = 1'b0;
    sd  = 1'b0;
    rdy = ~rst;
    foreach (q[i]) begin
      if (q[i].acc < t && t < q[i].start) rdy = 1'b0;
      o = t - q[i].start;
      if (o >= 0 && o < 2 * dw) begin
        ov = 1'b1;
        ws = (o >= dw);
        sd = (o < dw) ? q[i].l[dw-1-o] : q[i].r[2*dw-1-o];
      end
    end
  endtask

  task automatic model_accept(input int w, input int c,
                              input logic [31:0] l,
                              input logic [31:0] r);
    frame_t f;
    int dw;
    dw      = w ? 16 : 32;
    f.acc   = c;
    f.l     = l;
    f.r     = r;
    f.start = c + 2;
    if (w == 0) begin
      if (end0 > f.start) f.start = end0;
      end0 = f.start + 2 * dw;
      q0.push_back(f);
    end else begin
      if (end1 > f.start) f.start = end1;
      end1 = f.start + 2 * dw;
      q1.push_back(f);
    end
  endtask

  task automatic check_now();
    logic ov, ws, sd, rdy;
    while (q0.size() > 0 && q0[0].start + 64 <= cyc)
      void'(q0.pop_front());
    while (q1.size() > 0 && q1[0].start + 32 <= cyc)
      void'(q1.pop_front());
    expect_at(0, cyc, ov, ws, sd, rdy);
    chk("ov32", {31'd0, d.out_valid}, {31'd0, ov});
    chk("ws32", {31'd0, d.WS}, {31'd0, ws});
    chk("sd32", {31'd0, d.SD}, {31'd0, sd});
    chk("rdy32", {31'd0, d.in_ready}, {31'd0, rdy});
    expect_at(1, cyc, ov, ws, sd, rdy);
    chk("ov16", {31'd0, e.out_valid}, {31'd0, ov});
    chk("ws16", {31'd0, e.WS}, {31'd0, ws});
    chk("sd16", {31'd0, e.SD}, {31'd0, sd});
    chk("rdy16", {31'd0, e.in_ready}, {31'd0, rdy});
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_now();
    if (d.out_valid) run0++;
    else begin
      if (run0 > 0) last0 = run0;
      run0 = 0;
    end
    if (e.out_valid) run1++;
    else begin
      if (run1 > 0) last1 = run1;
      run1 = 0;
    end
    if (rx_on && d.out_valid) begin
      if (!d.WS) rxl = {rxl[30:0], d.SD};
      else begin
        rxr = {rxr[30:0], d.SD};
        rxc++;
        if (rxc == 32) begin
          rcvd.push_back({rxl, rxr});
          rxc = 0;
        end
      end
    end
  endtask

  task automatic offer(input int w, input logic [31:0] l,
                       input logic [31:0] r);
    int n;
    n = 0;
    if (w == 0) begin
      d.in_valid = 1'b1;
      d.in_left  = l;
      d.in_right = r;
    end else begin
      e.in_valid = 1'b1;
      e.in_left  = l[15:0];
      e.in_right = r[15:0];
    end
    while (!(w ? e.in_ready : d.in_ready) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout",
          {31'd0, (w ? e.in_ready : d.in_ready)}, 32'd1);
    end else begin
      last_acc = cyc;
      model_accept(w, cyc, l, r);
      step();
    end
    if (w == 0) d.in_valid = 1'b0;
    else        e.in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] l, r;
    int s2start, target;
    d.in_valid = 0; d.in_left = '0; d.in_right = '0;
    e.in_valid = 0; e.in_left = '0; e.in_right = '0;
    cyc = 0; checks = 0; errors = 0;
    end0 = 0; end1 = 0;
    run0 = 0; last0 = 0; run1 = 0; last1 = 0;
    rx_on = 0; rxc = 0; rxl = '0; rxr = '0;
    #1;
    check_now();
    step();
    step();
    rst = 1'b0;
    step();
    chk("ready_after_rst", {31'd0, d.in_ready}, 32'd1);

    offer(0, 32'h8000_0001, 32'hFFFF_0000);
    repeat (70) step();
    chk("run_single", last0, 32'd64);

    offer(0, $urandom, $urandom);
    repeat (10) step();
    offer(0, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    s2start = q0[q0.size()-1].start;
    offer(0, $urandom, $urandom);
    chk("bp_accept_cycle", last_acc, s2start);
    repeat (200) step();
    chk("run_b2b", last0, 32'd192);

    offer(0, $urandom, $urandom);
    target = q0[q0.size()-1].start + 42;
    while (cyc < target) step();
    rst = 1'b1;
    #1;
    chk("rst_ov", {31'd0, d.out_valid}, 32'd0);
    chk("rst_ws", {31'd0, d.WS}, 32'd0);
    chk("rst_sd", {31'd0, d.SD}, 32'd0);
    chk("rst_rdy", {31'd0, d.in_ready}, 32'd0);
    q0.delete();
    q1.delete();
    end0 = 0;
    end1 = 0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("ready_after_abort", {31'd0, d.in_ready}, 32'd1);
    repeat (10) step();
    last0 = 0;

    rx_on = 1;
    for (int i = 0; i < 100; i++) begin
      l = $urandom;
      r = $urandom;
      sent.push_back({l, r});
      offer(0, l, r);
    end
    repeat (150) step();
    rx_on = 0;
    chk("rx_count", rcvd.size(), 32'd100);
    for (int i = 0; i < 100 && i < rcvd.size(); i++) begin
      chk("rx_left", rcvd[i][63:32], sent[i][63:32]);
      chk("rx_right", rcvd[i][31:0], sent[i][31:0]);
    end
    chk("run_loop", last0, 32'd6400);

    offer(1, 32'h0000_1234, 32'h0000_FEDC);
    repeat (40) step();
    chk("run16", last1, 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
